// File: rtl/op_share_arbiter_pkg.sv
// Shared FSM state type and default constants for the operator-sharing arbiter.
package op_share_arbiter_pkg;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_TIMEOUT    = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/op_share_arbiter_rr_select.sv
// Round-robin picker: first requesting client after last_grant, wrapping modulo NUM_REQ.
module rr_select
    import op_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IW      = idx_width(DEF_NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last_grant,
    output logic               valid,
    output logic [IW-1:0]      grant
);

    logic [IW-1:0] cand;

    // Scan from the farthest offset down so the nearest requester is the last assignment.
    always_comb begin
        valid = 1'b0;
        grant = '0;
        cand  = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand = IW'((int'(last_grant) + off) % NUM_REQ);
            if (req[cand]) begin
                valid = 1'b1;
                grant = cand;
            end
        end
    end

endmodule

// File: rtl/op_share_arbiter.sv
// Arbitrates NUM_REQ clients onto one shared operator with timeout recovery.
// Optional per-client grant counters are enabled by OP_SHARE_ARBITER_STATS_EN.
module op_share_arbiter
    import op_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int data_width = DEF_DATA_WIDTH,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*2*data_width-1:0] din,
    output logic [NUM_REQ-1:0]              ack,
    output logic [data_width-1:0]           dout,
    output logic                            err,
    output logic                            op_req,
    output logic [2*data_width-1:0]         op_din,
    input  logic                            op_ack,
    input  logic [data_width-1:0]           op_dout
`ifdef OP_SHARE_ARBITER_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]           grant_count
`endif
);

    localparam int            IW         = idx_width(NUM_REQ);
    localparam int            PW         = 2 * data_width;
    localparam logic [IW-1:0] LAST_RESET = IW'(NUM_REQ - 1);
    localparam logic [15:0]   TO_LIMIT   = 16'(TIMEOUT - 1);

    state_t        state, state_next;
    logic [IW-1:0] last_grant, grant, rr_grant;
    logic          rr_valid;
    logic [15:0]   to_cnt;
    logic [PW-1:0] sel_operands;
    logic          timed_out;

    rr_select #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr (
        .req        (req),
        .last_grant (last_grant),
        .valid      (rr_valid),
        .grant      (rr_grant)
    );

    // Last ISSUE cycle allowed: leave with err if the operator still has not answered.
    assign timed_out = (state == ISSUE) && !op_ack && (to_cnt == TO_LIMIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (rr_valid) state_next = ISSUE;
            ISSUE: begin
                if (op_ack)         state_next = RESP;
                else if (timed_out) state_next = IDLE;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        op_req = (state == ISSUE);
        ack    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            ack[i] = (state == RESP) && (grant == IW'(i));
        end
    end

    always_comb begin
        sel_operands = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rr_grant == IW'(i)) sel_operands = din[i*PW +: PW];
        end
    end

    // Operands are frozen at grant time so client-side changes during ISSUE are invisible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant      <= '0;
            last_grant <= LAST_RESET;
            op_din     <= '0;
            dout       <= '0;
            to_cnt     <= '0;
            err        <= 1'b0;
        end else begin
            err <= timed_out;
            if (state == IDLE && rr_valid) begin
                grant  <= rr_grant;
                op_din <= sel_operands;
                to_cnt <= '0;
            end
            if (state == ISSUE) begin
                if (op_ack) dout   <= op_dout;
                else        to_cnt <= to_cnt + 16'd1;
            end
            if (state == RESP) last_grant <= grant;
        end
    end

`ifdef OP_SHARE_ARBITER_STATS_EN
    logic [31:0] stat_cnt [NUM_REQ];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REQ; i++) stat_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (ack[i]) stat_cnt[i] <= stat_cnt[i] + 32'd1;
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
        assign grant_count[g*32 +: 32] = stat_cnt[g];
    end
`endif

endmodule

// File: tb/tb_op_share_arbiter.sv
// Directed self-checking bench for op_share_arbiter with a behavioural adder operator.
module tb_op_share_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int TO = 8;

    logic               clk;
    logic               rst;
    logic [N-1:0]       req;
    logic [N*2*W-1:0]   din;
    logic [N-1:0]       ack;
    logic [W-1:0]       dout;
    logic               err;
    logic               op_req;
    logic [2*W-1:0]     op_din;
    logic               op_ack;
    logic [W-1:0]       op_dout;
`ifdef OP_SHARE_ARBITER_STATS_EN
    logic [N*32-1:0]    grant_count;
`endif

    logic op_en;
    logic stray_ack;
    int   op_lat;
    int   wait_cnt;
    int   errors;
    int   checks;

    op_share_arbiter #(
        .NUM_REQ    (N),
        .data_width (W),
        .TIMEOUT    (TO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .din     (din),
        .ack     (ack),
        .dout    (dout),
        .err     (err),
        .op_req  (op_req),
        .op_din  (op_din),
        .op_ack  (op_ack),
        .op_dout (op_dout)
`ifdef OP_SHARE_ARBITER_STATS_EN
        ,
        .grant_count (grant_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Operator model: adds a+b and acks on the op_lat-th ISSUE cycle when enabled.
    assign op_ack  = (op_req && op_en && (wait_cnt == op_lat - 1)) || stray_ack;
    assign op_dout = op_din[2*W-1:W] + op_din[W-1:0];

    always @(posedge clk) wait_cnt <= (op_req && !op_ack) ? wait_cnt + 1 : 0;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int client, input logic [W-1:0] a, input logic [W-1:0] b);
        din[client*2*W +: 2*W] = {b, a};
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    int            exp_sum [5] = '{11, 22, 33, 44, 11};
    logic [N-1:0]  exp_ack [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        errors    = 0;
        checks    = 0;
        rst       = 1'b0;
        req       = '0;
        din       = '0;
        op_en     = 1'b1;
        op_lat    = 2;
        stray_ack = 1'b0;
        for (int i = 0; i < N; i++) applyStimulus(i, 32'(10 * (i + 1)), 32'(i + 1));

        step(2);
        $display("[TB] reset state");
        checkOutput("rst_ack",    128'(ack),    128'(0));
        checkOutput("rst_err",    128'(err),    128'(0));
        checkOutput("rst_op_req", 128'(op_req), 128'(0));
        checkOutput("rst_dout",   128'(dout),   128'(0));
        checkOutput("rst_op_din", 128'(op_din), 128'(0));
        rst = 1'b1;
        step(1);

        $display("[TB] all clients held, 2-cycle operator");
        req = 4'b1111;
        step(2);
        checkOutput("rot_gap0", 128'(ack), 128'(0));
        step(1);
        checkOutput("rot_ack0",  128'(ack),  128'(exp_ack[0]));
        checkOutput("rot_dout0", 128'(dout), 128'(exp_sum[0]));
        for (int k = 1; k < 5; k++) begin
            step(3);
            checkOutput("rot_gap", 128'(ack), 128'(0));
            step(1);
            checkOutput("rot_ack",  128'(ack),  128'(exp_ack[k]));
            checkOutput("rot_dout", 128'(dout), 128'(exp_sum[k]));
        end
        req = '0;
        step(2);

        $display("[TB] single client 2, first-cycle operator ack");
        op_lat = 1;
        applyStimulus(2, 32'd5, 32'd7);
        req = 4'b0100;
        step(1);
        checkOutput("single_op_req", 128'(op_req), 128'(1));
        checkOutput("single_op_din", 128'(op_din), 128'({32'd7, 32'd5}));
        checkOutput("single_ack_early", 128'(ack), 128'(0));
        step(1);
        checkOutput("single_ack",  128'(ack),  128'(4'b0100));
        checkOutput("single_dout", 128'(dout), 128'(12));
        req = '0;
        step(1);
        checkOutput("single_ack_done", 128'(ack),    128'(0));
        checkOutput("single_idle_req", 128'(op_req), 128'(0));
        step(1);

        $display("[TB] operand change during ISSUE");
        op_lat = 3;
        applyStimulus(1, 32'd100, 32'd23);
        req = 4'b0010;
        step(1);
        checkOutput("hold_op_din0", 128'(op_din), 128'({32'd23, 32'd100}));
        applyStimulus(1, 32'd2, 32'd1);
        step(1);
        checkOutput("hold_op_din1", 128'(op_din), 128'({32'd23, 32'd100}));
        checkOutput("hold_op_req",  128'(op_req), 128'(1));
        step(1);
        checkOutput("hold_ack_wait", 128'(ack), 128'(0));
        step(1);
        checkOutput("hold_ack",  128'(ack),  128'(4'b0010));
        checkOutput("hold_dout", 128'(dout), 128'(123));
        req = '0;
        step(2);

        $display("[TB] stray op_ack in IDLE");
        stray_ack = 1'b1;
        step(1);
        stray_ack = 1'b0;
        checkOutput("stray_dout",   128'(dout),   128'(123));
        checkOutput("stray_ack",    128'(ack),    128'(0));
        checkOutput("stray_op_req", 128'(op_req), 128'(0));
        step(1);

        $display("[TB] operator timeout");
        op_en = 1'b0;
        applyStimulus(3, 32'd8, 32'd9);
        applyStimulus(0, 32'd10, 32'd1);
        req = 4'b1001;
        step(1);
        checkOutput("to_entry_op_din", 128'(op_din), 128'({32'd9, 32'd8}));
        step(7);
        checkOutput("to_last_op_req", 128'(op_req), 128'(1));
        checkOutput("to_last_err",    128'(err),    128'(0));
        checkOutput("to_last_ack",    128'(ack),    128'(0));
        step(1);
        checkOutput("to_err",    128'(err),    128'(1));
        checkOutput("to_op_req", 128'(op_req), 128'(0));
        checkOutput("to_ack",    128'(ack),    128'(0));
        op_en  = 1'b1;
        op_lat = 1;
        step(1);
        checkOutput("to_regrant_op_din", 128'(op_din), 128'({32'd9, 32'd8}));
        checkOutput("to_err_cleared",    128'(err),    128'(0));
        step(1);
        checkOutput("to_regrant_ack",  128'(ack),  128'(4'b1000));
        checkOutput("to_regrant_dout", 128'(dout), 128'(17));
        req = '0;
        step(2);

        $display("[TB] reset during ISSUE");
        op_en = 1'b0;
        req   = 4'b0100;
        step(2);
        checkOutput("mid_op_req_before", 128'(op_req), 128'(1));
        rst = 1'b0;
        #1;
        checkOutput("mid_op_req", 128'(op_req), 128'(0));
        checkOutput("mid_ack",    128'(ack),    128'(0));
        checkOutput("mid_err",    128'(err),    128'(0));
        checkOutput("mid_op_din", 128'(op_din), 128'(0));
        checkOutput("mid_dout",   128'(dout),   128'(0));
        step(1);
        checkOutput("mid_hold_err", 128'(err), 128'(0));
        checkOutput("mid_hold_ack", 128'(ack), 128'(0));
        rst    = 1'b1;
        req    = 4'b0101;
        op_en  = 1'b1;
        op_lat = 1;
        step(1);
        checkOutput("post_rst_op_din", 128'(op_din), 128'({32'd1, 32'd10}));
        step(1);
        checkOutput("post_rst_ack",  128'(ack),  128'(4'b0001));
        checkOutput("post_rst_dout", 128'(dout), 128'(11));
        req = '0;
        step(2);

        $display("[TB] ten transactions on client 1");
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        applyStimulus(1, 32'd20, 32'd2);
        req = 4'b0010;
        step(2);
        checkOutput("c1_ack", 128'(ack), 128'(4'b0010));
        for (int k = 1; k < 10; k++) begin
            step(1);
            checkOutput("c1_no_regrant", 128'(op_req), 128'(0));
            step(2);
            checkOutput("c1_ack", 128'(ack), 128'(4'b0010));
        end
        req = '0;
        step(1);
        checkOutput("c1_ack_done", 128'(ack), 128'(0));
`ifdef OP_SHARE_ARBITER_STATS_EN
        checkOutput("stat_c0", 128'(grant_count[31:0]),   128'(0));
        checkOutput("stat_c1", 128'(grant_count[63:32]),  128'(10));
        checkOutput("stat_c2", 128'(grant_count[95:64]),  128'(0));
        checkOutput("stat_c3", 128'(grant_count[127:96]), 128'(0));
`endif
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
